// File: rtl/keypad_pkg.sv
// Shared types and geometry for the 4x4 matrix keypad scanner.
// Key code of a switch is row*NUM_COLS + col.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic {
    IDLE,
    PRESSED
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_class_t;

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the active-low keypad rows; 2-cycle latency, no backpressure.
// Resets to all-ones, which reads as no key closed.
module row_sync
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_ROWS-1:0] row_s
);

  logic [NUM_ROWS-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= '1;
      row_s <= '1;
    end else begin
      meta  <= row_in;
      row_s <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans and debounces a 4x4 active-low keypad; one key_valid pulse per accepted press,
// at most DEBOUNCE_SCANS+1 scans + 2 cycles after a clean press; no backpressure.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  input  logic                clear_entry,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic [31:0]         entry_data
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [NUM_ROWS-1:0] row_s;
  logic [DIV_W-1:0]    div;
  logic [1:0]          col;
  logic [NUM_KEYS-1:0] snap;
  logic [NUM_KEYS-1:0] snap_cur;
  logic                sample;
  logic                scan_done;

  scan_class_t cls, cand_cls;
  logic [3:0]  hit, cand_key;
  logic [4:0]  ones;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic        same, stable, press;
  kp_state_t   state, state_nxt;

  row_sync u_row_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .row_in (row_in),
    .row_s  (row_s)
  );

  assign sample    = (div == DIV_W'(SCAN_DIV - 1));
  assign scan_done = sample && (col == 2'd3);
  assign col_out   = ~(4'b0001 << col);

  // Snapshot with the column being sampled this cycle merged in, so the
  // column-3 result is visible to the classifier on the completing cycle.
  always_comb begin
    snap_cur = snap;
    for (int r = 0; r < NUM_ROWS; r++) begin
      snap_cur[r*NUM_COLS + int'(col)] = ~row_s[r];
    end
  end

  always_comb begin
    ones = '0;
    hit  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (snap_cur[i]) begin
        ones = ones + 5'd1;
        hit  = 4'(i);
      end
    end
    if (ones == 5'd0)      cls = NONE;
    else if (ones == 5'd1) cls = SINGLE;
    else                   cls = MULTI;
  end

  always_comb begin
    same = (cls == cand_cls) && ((cls != SINGLE) || (hit == cand_key));
    if (!same)                                cnt_nxt = CNT_W'(1);
    else if (cnt == CNT_W'(DEBOUNCE_SCANS))   cnt_nxt = cnt;
    else                                      cnt_nxt = cnt + CNT_W'(1);
    stable = scan_done && (cnt_nxt == CNT_W'(DEBOUNCE_SCANS));
  end

  always_comb begin
    state_nxt = state;
    press     = 1'b0;
    case (state)
      IDLE: begin
        if (stable && cls == SINGLE) begin
          state_nxt = PRESSED;
          press     = 1'b1;
        end
      end
      PRESSED: begin
        // Only a debounced all-clear re-arms; other keys never emit.
        if (stable && cls == NONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div        <= '0;
      col        <= '0;
      snap       <= '0;
      cand_cls   <= NONE;
      cand_key   <= '0;
      cnt        <= '0;
      state      <= IDLE;
      key_valid  <= 1'b0;
      key_code   <= '0;
      entry_data <= '0;
    end else begin
      div <= sample ? '0 : div + DIV_W'(1);
      if (sample) begin
        col  <= col + 2'd1;
        snap <= scan_done ? '0 : snap_cur;
      end
      if (scan_done) begin
        cand_cls <= cls;
        cand_key <= hit;
        cnt      <= cnt_nxt;
      end
      state     <= state_nxt;
      key_valid <= press;
      if (press) key_code <= hit;
      if (clear_entry)
        entry_data <= press ? {28'h0, hit} : 32'h0;
      else if (press)
        entry_data <= {entry_data[27:0], hit};
    end
  end

endmodule
